// File: rtl/mul_pkg.sv
// Shared encodings for the multiplier issue controller: M-extension op codes
// and the sequencer state encoding.
// Latency: n/a (declarations only). Backpressure: n/a.
package mul_pkg;

  localparam logic [1:0] MUL_OP_MUL    = 2'd0;
  localparam logic [1:0] MUL_OP_MULH   = 2'd1;
  localparam logic [1:0] MUL_OP_MULHSU = 2'd2;
  localparam logic [1:0] MUL_OP_MULHU  = 2'd3;

  typedef enum logic {
    IDLE      = 1'b0,
    HIGH_WAIT = 1'b1
  } mul_state_e;

endpackage

// File: rtl/mul_opnd_ext.sv
// Operand extension 32->33 bits for the signed 33x33 MAC, chosen per M-op.
// Latency: purely combinational. Backpressure: none (no state).
// Ports: op (M-op code), rs1/rs2 (raw operands), din1/din2 (extended operands).
module mul_opnd_ext
  import mul_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [32:0] din1,
  output logic [32:0] din2
);

  logic sgn1;
  logic sgn2;

  // rs1 is signed for everything except MULHU; rs2 only for MUL/MULH.
  assign sgn1 = (op != MUL_OP_MULHU);
  assign sgn2 = (op == MUL_OP_MUL) || (op == MUL_OP_MULH);

  assign din1 = {sgn1 & rs1[31], rs1};
  assign din2 = {sgn2 & rs2[31], rs2};

endmodule

// File: rtl/mul_issue_ctrl.sv
// Sequencer in front of the 33-bit MAC: issues MUL/MULH* ops, captures the
// low word (1 cycle accept->result) or high word (2 cycles), holds one result.
// Backpressure: req_ready drops while busy, paused, flushing or result unread.
// Ports: clk/reset, pause/flush, req_* (dispatch), mac_* (MAC), res_* (writeback).
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pause,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [31:0]     req_rs1,
  input  logic [31:0]     req_rs2,
  input  logic [TAGW-1:0] req_tag,
  output logic            mac_pause,
  output logic            mac_mul_en,
  output logic            mac_low,
  output logic            mac_high,
  output logic [32:0]     mac_din1,
  output logic [32:0]     mac_din2,
  input  logic [31:0]     mac_dlout,
  input  logic [31:0]     mac_dhout,
  input  logic            mac_vldout,
  input  logic            mac_vhdout,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [31:0]     res_data,
  output logic [TAGW-1:0] res_tag
);

  mul_state_e      state;
  mul_state_e      state_nxt;
  logic            accept;
  logic            is_mul;
  logic            cap_lo;
  logic            cap_hi;
  logic [32:0]     ext1;
  logic [32:0]     ext2;
  logic [TAGW-1:0] hi_tag;

  assign mac_pause = pause;

  // Gated by reset so no MAC control can leak out while the block is held.
  assign req_ready = reset & !pause & !flush & (state == IDLE) &
                     (!res_valid | res_ready);
  assign accept    = req_valid & req_ready;
  assign is_mul    = (req_op == MUL_OP_MUL);

  mul_opnd_ext u_opnd_ext (
    .op   (req_op),
    .rs1  (req_rs1),
    .rs2  (req_rs2),
    .din1 (ext1),
    .din2 (ext2)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // MAC controls and operands are only non-zero in the accept cycle; the low
  // word comes back combinationally and is captured on that same edge.
  always_comb begin
    state_nxt  = state;
    mac_mul_en = 1'b0;
    mac_low    = 1'b0;
    mac_high   = 1'b0;
    mac_din1   = '0;
    mac_din2   = '0;
    cap_lo     = 1'b0;
    cap_hi     = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
    end else if (!pause) begin
      case (state)
        IDLE: begin
          if (accept) begin
            mac_mul_en = 1'b1;
            mac_din1   = ext1;
            mac_din2   = ext2;
            if (is_mul) begin
              mac_low = 1'b1;
              cap_lo  = mac_vldout;
            end else begin
              mac_high  = 1'b1;
              state_nxt = HIGH_WAIT;
            end
          end
        end
        HIGH_WAIT: begin
          // Without mac_vhdout we simply wait; that case is a MAC fault.
          if (mac_vhdout) begin
            cap_hi    = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Result holding register. Flush beats pause; a capture in the same cycle
  // as a drain overwrites and keeps res_valid high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_tag   <= '0;
      hi_tag    <= '0;
    end else if (flush) begin
      res_valid <= 1'b0;
    end else if (!pause) begin
      if (accept && !is_mul) hi_tag <= req_tag;
      if (cap_lo) begin
        res_valid <= 1'b1;
        res_data  <= mac_dlout;
        res_tag   <= req_tag;
      end else if (cap_hi) begin
        res_valid <= 1'b1;
        res_data  <= mac_dhout;
        res_tag   <= hi_tag;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  hw_needs_vhd: assert property (@(posedge clk) disable iff (!reset)
    (state == HIGH_WAIT && !pause && !flush) |-> mac_vhdout);
`endif

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl with a behavioural MAC model and a
// result scoreboard fed on every accepted request.
module tb_mul_issue_ctrl;

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULH   = 2'd1;
  localparam logic [1:0] OP_MULHSU = 2'd2;
  localparam logic [1:0] OP_MULHU  = 2'd3;

  logic        clk;
  logic        reset;
  logic        pause;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_tag;
  logic        mac_pause;
  logic        mac_mul_en;
  logic        mac_low;
  logic        mac_high;
  logic [32:0] mac_din1;
  logic [32:0] mac_din2;
  logic [31:0] mac_dlout;
  logic [31:0] mac_dhout;
  logic        mac_vldout;
  logic        mac_vhdout;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_tag;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;
  exp_t sb[$];

  mul_issue_ctrl #(.TAGW(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .pause      (pause),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_tag    (req_tag),
    .mac_pause  (mac_pause),
    .mac_mul_en (mac_mul_en),
    .mac_low    (mac_low),
    .mac_high   (mac_high),
    .mac_din1   (mac_din1),
    .mac_din2   (mac_din2),
    .mac_dlout  (mac_dlout),
    .mac_dhout  (mac_dhout),
    .mac_vldout (mac_vldout),
    .mac_vhdout (mac_vhdout),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_tag    (res_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MAC: low word same cycle, high word registered one cycle later,
  // held while paused, cleared by the shared reset.
  logic signed [65:0] prod;
  logic [31:0]        hreg;
  logic               hv;
  assign prod       = $signed(mac_din1) * $signed(mac_din2);
  assign mac_dlout  = prod[31:0];
  assign mac_vldout = mac_mul_en & mac_low;
  assign mac_dhout  = hreg;
  assign mac_vhdout = hv;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      hv   <= 1'b0;
      hreg <= '0;
    end else if (!mac_pause) begin
      hv <= mac_mul_en & mac_high;
      if (mac_mul_en && mac_high) hreg <= prod[63:32];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] sa, za, sbv, zb, p;
    sa  = {{32{a[31]}}, a};
    za  = {32'b0, a};
    sbv = {{32{b[31]}}, b};
    zb  = {32'b0, b};
    case (op)
      OP_MUL:    begin p = za * zb;  return p[31:0];  end
      OP_MULH:   begin p = sa * sbv; return p[63:32]; end
      OP_MULHSU: begin p = sa * zb;  return p[63:32]; end
      default:   begin p = za * zb;  return p[63:32]; end
    endcase
  endfunction

  // Scoreboard: push on accepted request, pop on completed writeback.
  always @(negedge clk) begin
    exp_t e;
    if (res_valid && res_ready && !pause && !flush) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        check_eq("sb_data", res_data, e.data);
        check_eq("sb_tag", res_tag, e.tag);
      end
    end
    if (req_valid && req_ready)
      sb.push_back('{data: ref_res(req_op, req_rs1, req_rs2), tag: req_tag});
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Caller is aligned just after a rising edge; returns aligned after accept.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag);
    bit ok;
    ok        = 1'b0;
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    req_tag   = tag;
    req_valid = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      ok = req_ready;
      tick();
    end
    req_valid = 1'b0;
    if (!ok) check_eq("send_timeout", 0, 1);
  endtask

  task automatic hi_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp);
    send(op, a, b, tag);
    @(negedge clk);
    check_eq("hi_lat_not_yet", res_valid, 0);
    check_eq("hi_busy_rdy", req_ready, 0);
    tick();
    @(negedge clk);
    check_eq("hi_lat_valid", res_valid, 1);
    check_eq("hi_data", res_data, exp);
    check_eq("hi_tag", res_tag, tag);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    reset     = 1'b1;
    pause     = 1'b0;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_op    = OP_MUL;
    req_rs1   = 32'h0;
    req_rs2   = 32'h0;
    req_tag   = 5'd0;
    res_ready = 1'b1;
    #1 reset = 1'b0;
    req_valid = 1'b1;
    req_rs1   = 32'h1234;
    req_rs2   = 32'h5678;
    #1;
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_res_data", res_data, 0);
    check_eq("rst_res_tag", res_tag, 0);
    check_eq("rst_mul_en", mac_mul_en, 0);
    check_eq("rst_din1", mac_din1, 0);
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;

    // MUL: one-cycle latency, operand extension visible in the accept cycle.
    tick();
    req_op = OP_MUL; req_rs1 = 32'hFFFFFFFF; req_rs2 = 32'h2; req_tag = 5'd3;
    req_valid = 1'b1;
    @(negedge clk);
    check_eq("mul_rdy", req_ready, 1);
    check_eq("mul_din1", mac_din1, 33'h1FFFFFFFF);
    check_eq("mul_din2", mac_din2, 33'h000000002);
    check_eq("mul_ctl", {mac_mul_en, mac_low, mac_high}, 3'b110);
    check_eq("mul_lat0", res_valid, 0);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("mul_lat1", res_valid, 1);
    check_eq("mul_data", res_data, 32'hFFFFFFFE);
    check_eq("mul_tag", res_tag, 3);
    check_eq("idle_ctl", {mac_mul_en, mac_low, mac_high}, 3'b000);
    check_eq("idle_din1", mac_din1, 0);
    tick();

    // High-word ops: two-cycle latency.
    hi_op(OP_MULH,   32'h80000000, 32'h80000000, 5'd1, 32'h40000000);
    hi_op(OP_MULHU,  32'h80000000, 32'h80000000, 5'd2, 32'h40000000);
    hi_op(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF);

    // Back-to-back MUL, MULHU, MUL.
    send(OP_MUL, 32'd3, 32'd4, 5'd5);
    send(OP_MULHU, 32'hFFFFFFFF, 32'd2, 5'd6);
    @(negedge clk);
    check_eq("b2b_rdy_hw", req_ready, 0);
    tick();
    send(OP_MUL, 32'hFFFFFFF9, 32'd6, 5'd7);
    @(negedge clk);
    check_eq("b2b_last_valid", res_valid, 1);
    tick();
    tick();

    // Writeback stall holds the result and blocks new requests.
    res_ready = 1'b0;
    send(OP_MUL, 32'd7, 32'd6, 5'd8);
    @(negedge clk);
    check_eq("stall_valid", res_valid, 1);
    check_eq("stall_rdy", req_ready, 0);
    held = res_data;
    check_eq("stall_data", held, 32'd42);
    tick();
    req_op = OP_MUL; req_rs1 = 32'd11; req_rs2 = 32'd13; req_tag = 5'd9; req_valid = 1'b1;
    @(negedge clk);
    check_eq("stall_rdy2", req_ready, 0);
    check_eq("stall_stable", res_data, held);
    tick();
    res_ready = 1'b1;
    @(negedge clk);
    check_eq("drain_accept", req_ready, 1);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("drain_next", res_data, 32'd143);
    check_eq("drain_next_tag", res_tag, 9);
    tick();

    // Pause held three cycles in HIGH_WAIT.
    send(OP_MULH, 32'h12345678, 32'h9ABCDEF0, 5'd10);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("pause_no_cap", res_valid, 0);
      check_eq("pause_fwd", mac_pause, 1);
      check_eq("pause_rdy", req_ready, 0);
      tick();
    end
    pause = 1'b0;
    @(negedge clk);
    check_eq("pause_rel_wait", res_valid, 0);
    tick();
    @(negedge clk);
    check_eq("pause_rel_cap", res_valid, 1);
    check_eq("pause_hi_data", res_data, ref_res(OP_MULH, 32'h12345678, 32'h9ABCDEF0));
    tick();

    // Flush in HIGH_WAIT: op is killed, stale MAC high word ignored.
    send(OP_MULH, 32'd3, 32'd5, 5'd11);
    flush = 1'b1;
    @(negedge clk);
    check_eq("flush_rdy", req_ready, 0);
    tick();
    flush = 1'b0;
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("flush_no_res", res_valid, 0);
      check_eq("flush_idle", req_ready, 1);
      tick();
    end

    // Flush overrides pause on a held result.
    res_ready = 1'b0;
    send(OP_MUL, 32'd5, 32'd5, 5'd12);
    pause = 1'b1;
    flush = 1'b1;
    tick();
    pause = 1'b0;
    flush = 1'b0;
    sb.delete();
    @(negedge clk);
    check_eq("flush_pause", res_valid, 0);
    tick();

    // Async reset while a result is held and a request is pending.
    send(OP_MUL, 32'd9, 32'd9, 5'd13);
    #2;
    reset = 1'b0;
    req_op = OP_MUL; req_rs1 = 32'd5; req_rs2 = 32'd5; req_tag = 5'd1; req_valid = 1'b1;
    #1;
    check_eq("arst_valid", res_valid, 0);
    check_eq("arst_data", res_data, 0);
    check_eq("arst_tag", res_tag, 0);
    check_eq("arst_ctl", {mac_mul_en, mac_low, mac_high}, 3'b000);
    check_eq("arst_din1", mac_din1, 0);
    sb.delete();
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    res_ready = 1'b1;
    tick();

    // Async reset mid-HIGH_WAIT.
    send(OP_MULH, 32'd7, 32'd7, 5'd14);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_hw_valid", res_valid, 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    tick();
    @(negedge clk);
    check_eq("arst_hw_nores", res_valid, 0);
    check_eq("arst_hw_idle", req_ready, 1);
    tick();
    tick();

    check_eq("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
